// File: rtl/lfsr_4bit_checker_if.sv
// Sample stream from the 4-bit LFSR generator plus the checker's status outputs.
interface lfsr_4bit_checker_if #(
  parameter int unsigned ERR_CNT_W = 16
) ();
  logic                 in_valid;
  logic [3:0]           in_data;
  logic                 locked;
  logic                 err_pulse;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 zero_seen;

  modport master (
    output in_valid, in_data,
    input  locked, err_pulse, err_count, zero_seen
  );

  modport slave (
    input  in_valid, in_data,
    output locked, err_pulse, err_count, zero_seen
  );
endinterface

// File: rtl/lfsr_4bit_checker.sv
// Checks a received 4-bit LFSR stream: locks to the sequence, counts mismatches while locked,
// and drops lock after ERR_LIMIT consecutive misses.
module lfsr_4bit_checker #(
  parameter int unsigned LOCK_COUNT = 3,
  parameter int unsigned ERR_LIMIT  = 4,
  parameter int unsigned ERR_CNT_W  = 16
) (
  input logic                clk,
  input logic                rst,
  lfsr_4bit_checker_if.slave bus
);

  localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);
  localparam logic [3:0] ErrLim  = 4'(ERR_LIMIT);

  typedef enum logic [1:0] {StIdle, StSearch, StLocked} state_e;

  state_e               state_q, state_d;
  logic [3:0]           ref_q, ref_d;
  logic [3:0]           match_cnt_q, match_cnt_d;
  logic [3:0]           miss_cnt_q, miss_cnt_d;
  logic                 locked_q, locked_d;
  logic                 err_pulse_q, err_pulse_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic                 zero_seen_q, zero_seen_d;

  logic [3:0] predicted;
  logic       hit;

  assign predicted = {ref_q[2:0], ref_q[2] ^ ref_q[3]};
  assign hit       = (bus.in_data == predicted);

  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    zero_seen_d = zero_seen_q;

    if (bus.in_valid) begin
      if (bus.in_data == 4'h0) zero_seen_d = 1'b1;

      unique case (state_q)
        StIdle: begin
          ref_d       = bus.in_data;
          match_cnt_d = 4'd0;
          state_d     = StSearch;
        end
        StSearch: begin
          ref_d = bus.in_data;
          if (hit) begin
            match_cnt_d = match_cnt_q + 4'd1;
            if (match_cnt_q + 4'd1 == LockCnt) begin
              state_d    = StLocked;
              locked_d   = 1'b1;
              miss_cnt_d = 4'd0;
            end
          end else begin
            match_cnt_d = 4'd0;
          end
        end
        StLocked: begin
          if (hit) begin
            ref_d      = bus.in_data;
            miss_cnt_d = 4'd0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + ERR_CNT_W'(1);
            miss_cnt_d = miss_cnt_q + 4'd1;
            // Flywheel over a single bad sample instead of resyncing to it.
            ref_d      = predicted;
            if (miss_cnt_q + 4'd1 == ErrLim) begin
              state_d     = StSearch;
              locked_d    = 1'b0;
              match_cnt_d = 4'd0;
              ref_d       = bus.in_data;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ref_q       <= 4'd0;
      match_cnt_q <= 4'd0;
      miss_cnt_q  <= 4'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      zero_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      zero_seen_q <= zero_seen_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;
  assign bus.zero_seen = zero_seen_q;

endmodule

// File: tb/tb_lfsr_4bit_checker.sv
// Bench for lfsr_4bit_checker: directed vector table, hand sequences and random stream,
// with two instances (default parameters and a narrow saturating counter).
module tb_lfsr_4bit_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lfsr_4bit_checker_if #(.ERR_CNT_W(16)) bus1 ();
  lfsr_4bit_checker_if #(.ERR_CNT_W(2))  bus2 ();

  lfsr_4bit_checker #(.LOCK_COUNT(3), .ERR_LIMIT(4), .ERR_CNT_W(16)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  lfsr_4bit_checker #(.LOCK_COUNT(3), .ERR_LIMIT(15), .ERR_CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int n_vec = 0;
  int n_mis = 0;

  // Legal cycle as a lookup table; successor found by position, 0 maps to itself.
  logic [3:0] cyc [15] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
                           4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7};

  function automatic logic [3:0] succ(logic [3:0] x);
    for (int i = 0; i < 15; i++) if (cyc[i] == x) return cyc[(i + 1) % 15];
    return 4'h0;
  endfunction

  typedef struct {
    bit         started;
    bit         lk;
    int         run;
    int         miss;
    logic [3:0] anchor;
    int         errs;
    bit         zs;
    bit         ep;
  } model_t;

  model_t m [2];
  int lock_n [2] = '{3, 3};
  int lim    [2] = '{4, 15};
  int cmax   [2] = '{65535, 3};

  task automatic model_reset(int k);
    m[k].started = 0; m[k].lk = 0; m[k].run = 0; m[k].miss = 0;
    m[k].anchor = 4'h0; m[k].errs = 0; m[k].zs = 0; m[k].ep = 0;
  endtask

  task automatic model_step(int k, bit v, logic [3:0] d);
    m[k].ep = 0;
    if (!v) return;
    if (d == 4'h0) m[k].zs = 1;
    if (!m[k].started) begin
      m[k].started = 1;
      m[k].anchor  = d;
      m[k].run     = 0;
    end else if (!m[k].lk) begin
      if (d == succ(m[k].anchor)) begin
        m[k].run++;
        if (m[k].run == lock_n[k]) begin
          m[k].lk   = 1;
          m[k].miss = 0;
        end
      end else m[k].run = 0;
      m[k].anchor = d;
    end else if (d == succ(m[k].anchor)) begin
      m[k].anchor = d;
      m[k].miss   = 0;
    end else begin
      m[k].ep = 1;
      if (m[k].errs < cmax[k]) m[k].errs++;
      m[k].miss++;
      if (m[k].miss == lim[k]) begin
        m[k].lk     = 0;
        m[k].run    = 0;
        m[k].anchor = d;
      end else m[k].anchor = succ(m[k].anchor);
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_model(int k, bit lk, bit ep, int cnt, bit zs);
    chk($sformatf("dut%0d locked", k), int'(lk), int'(m[k].lk));
    chk($sformatf("dut%0d err_pulse", k), int'(ep), int'(m[k].ep));
    chk($sformatf("dut%0d err_count", k), cnt, m[k].errs);
    chk($sformatf("dut%0d zero_seen", k), int'(zs), int'(m[k].zs));
  endtask

  // One clock: drive, clock, sample #1 after the edge and compare both instances to the model.
  task automatic step(bit r, bit v, logic [3:0] d);
    rst = r;
    bus1.in_valid = v; bus1.in_data = d;
    bus2.in_valid = v; bus2.in_data = d;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (r) model_reset(k);
      else model_step(k, v, d);
    end
    cmp_model(0, bus1.locked, bus1.err_pulse, int'(bus1.err_count), bus1.zero_seen);
    cmp_model(1, bus2.locked, bus2.err_pulse, int'(bus2.err_count), bus2.zero_seen);
    rst = 1'b0;
  endtask

  task automatic feed_lock();
    step(1'b0, 1'b1, 4'hF); step(1'b0, 1'b1, 4'hE);
    step(1'b0, 1'b1, 4'hC); step(1'b0, 1'b1, 4'h8);
  endtask

  typedef struct {
    bit         r;
    bit         v;
    logic [3:0] d;
    bit         lk;
    bit         ep;
    int         cnt;
    bit         zs;
  } vec_t;

  vec_t tbl [$];

  task automatic add(bit r, bit v, logic [3:0] d, bit lk, bit ep, int cnt, bit zs);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.lk = lk; t.ep = ep; t.cnt = cnt; t.zs = zs;
    tbl.push_back(t);
  endtask

  initial begin
    int pulses;
    logic [3:0] gen;
    bit v;
    logic [3:0] d;

    bus1.in_valid = 1'b0; bus1.in_data = 4'h0;
    bus2.in_valid = 1'b0; bus2.in_data = 4'h0;

    // Lock acquisition, then single corruption with flywheel.
    add(1, 0, 4'h0, 0, 0, 0, 0);
    add(0, 1, 4'hF, 0, 0, 0, 0); add(0, 1, 4'hE, 0, 0, 0, 0);
    add(0, 1, 4'hC, 0, 0, 0, 0); add(0, 1, 4'h8, 1, 0, 0, 0);
    add(0, 1, 4'h1, 1, 0, 0, 0); add(0, 1, 4'h2, 1, 0, 0, 0);
    add(0, 1, 4'h0, 1, 1, 1, 1); add(0, 1, 4'h9, 1, 0, 1, 1);
    add(0, 1, 4'h3, 1, 0, 1, 1); add(0, 0, 4'h0, 1, 0, 1, 1);
    // Loss of lock after four misses, then relock.
    add(1, 0, 4'h0, 0, 0, 0, 0);
    add(0, 1, 4'hF, 0, 0, 0, 0); add(0, 1, 4'hE, 0, 0, 0, 0);
    add(0, 1, 4'hC, 0, 0, 0, 0); add(0, 1, 4'h8, 1, 0, 0, 0);
    add(0, 1, 4'h5, 1, 1, 1, 0); add(0, 1, 4'h5, 1, 1, 2, 0);
    add(0, 1, 4'h5, 1, 1, 3, 0); add(0, 1, 4'h5, 0, 1, 4, 0);
    add(0, 1, 4'hA, 0, 0, 4, 0); add(0, 1, 4'h5, 0, 0, 4, 0);
    add(0, 1, 4'hB, 0, 0, 4, 0); add(0, 1, 4'h7, 1, 0, 4, 0);
    // Valid gaps of three cycles between samples.
    add(1, 0, 4'h0, 0, 0, 0, 0);
    add(0, 1, 4'hF, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 4'h3, 0, 0, 0, 0);
    add(0, 1, 4'hE, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 4'h3, 0, 0, 0, 0);
    add(0, 1, 4'hC, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 4'h3, 0, 0, 0, 0);
    add(0, 1, 4'h8, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 4'h3, 1, 0, 0, 0);
    add(0, 1, 4'h1, 1, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl[%0d] locked", i), int'(bus1.locked), int'(tbl[i].lk));
      chk($sformatf("tbl[%0d] err_pulse", i), int'(bus1.err_pulse), int'(tbl[i].ep));
      chk($sformatf("tbl[%0d] err_count", i), int'(bus1.err_count), tbl[i].cnt);
      chk($sformatf("tbl[%0d] zero_seen", i), int'(bus1.zero_seen), int'(tbl[i].zs));
    end

    // Saturation on the 2-bit counter instance.
    step(1'b1, 1'b0, 4'h0);
    feed_lock();
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 4'h5);
      if (bus2.err_pulse) pulses++;
    end
    chk("sat err_count", int'(bus2.err_count), 3);
    chk("sat pulses", pulses, 6);
    chk("sat locked", int'(bus2.locked), 1);

    // Reset mid-operation, asserted together with a valid sample.
    step(1'b1, 1'b0, 4'h0);
    feed_lock();
    step(1'b0, 1'b1, 4'h1); step(1'b0, 1'b1, 4'h0);
    step(1'b0, 1'b1, 4'h4); step(1'b0, 1'b1, 4'h0);
    chk("pre-rst err_count", int'(bus1.err_count), 2);
    chk("pre-rst zero_seen", int'(bus1.zero_seen), 1);
    chk("pre-rst locked", int'(bus1.locked), 1);
    step(1'b1, 1'b1, 4'hF);
    chk("rst locked", int'(bus1.locked), 0);
    chk("rst err_count", int'(bus1.err_count), 0);
    chk("rst zero_seen", int'(bus1.zero_seen), 0);
    chk("rst err_pulse", int'(bus1.err_pulse), 0);
    feed_lock();
    chk("relock", int'(bus1.locked), 1);

    // Random stream: mostly legal samples, with corruption, gaps and rare resets.
    step(1'b1, 1'b0, 4'h0);
    gen = cyc[$urandom_range(14, 0)];
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(299, 0) == 0) begin
        step(1'b1, 1'b0, 4'h0);
        continue;
      end
      v = ($urandom_range(3, 0) != 0);
      d = ($urandom_range(9, 0) == 0) ? 4'($urandom_range(15, 0)) : gen;
      step(1'b0, v, d);
      if (v) gen = succ(gen);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/lfsr_4bit_checker.md
Name: lfsr_4bit_checker

Overview:
- Downstream consumer of the 4-bit LFSR generator.
- Receives the generator's 4-bit state one sample per valid cycle and predicts each next sample with the same recurrence.
- Locks onto the sequence, flags and counts mismatches, and drops lock after sustained errors.
- Used as an on-board self-check: locked/err_pulse drive status LEDs.

Parameters:
- LOCK_COUNT, 3: consecutive correct predictions needed to enter LOCKED (legal range 1 to 15).
- ERR_LIMIT, 4: consecutive mismatches while LOCKED that force a return to SEARCH (legal range 1 to 15).
- ERR_CNT_W, 16: width of the saturating error counter.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  in_data carries a sample this cycle.
- in_data  in  4  LFSR state sample.
- locked  out  1  checker is locked to the sequence.
- err_pulse  out  1  one-cycle strobe for each mismatch while LOCKED.
- err_count  out  ERR_CNT_W  saturating count of mismatches while LOCKED.
- zero_seen  out  1  sticky flag: a sample of 4'h0 (illegal lockup state) was received.

Behaviour:
- Recurrence: next(d) = {d[2], d[1], d[0], d[2]^d[3]}.
- Legal cycle from 4'hF, period 15: F,E,C,8,1,2,4,9,3,6,D,A,5,B,7,F.
- Internal registers: state, ref[3:0], match_cnt, miss_cnt (both 4 bits).
- Reset:
  - State IDLE; ref, match_cnt, miss_cnt = 0.
  - locked = 0, err_pulse = 0, err_count = 0, zero_seen = 0.
  - rst asserted mid-operation overrides everything and takes effect on that same edge.
- Gating and timing:
  - Cycles with in_valid = 0 change no state.
  - err_pulse is forced to 0 on any cycle where in_valid = 0.
  - All outputs are registered and update on the edge that samples the valid input, so they are visible from the next cycle (latency 1).
- IDLE, on valid: ref <= in_data, match_cnt <= 0, go to SEARCH.
- SEARCH, on valid:
  - If in_data == next(ref): match_cnt++. If match_cnt+1 == LOCK_COUNT, go to LOCKED, set locked <= 1, miss_cnt <= 0.
  - On mismatch: match_cnt <= 0.
  - ref <= in_data in both cases (resync to the received stream).
  - No err_pulse and no err_count change in SEARCH.
- LOCKED, on valid:
  - Match: ref <= in_data, miss_cnt <= 0.
  - Mismatch:
    - err_pulse <= 1 and err_count <= err_count+1, saturating at all ones (no wrap).
    - ref <= next(ref) (flywheel: a single corrupt sample costs exactly one error).
    - miss_cnt++.
    - If miss_cnt+1 == ERR_LIMIT: go to SEARCH, locked <= 0, match_cnt <= 0, ref <= in_data. err_pulse and err_count are still applied for this sample.
- zero_seen:
  - Set on any valid sample equal to 4'h0, in any state, and held until rst.
  - A zero sample is otherwise processed as an ordinary sample.
- err_count is never cleared by loss of lock; only rst clears it.
- Back-to-back valid cycles are supported at full rate.

Test Plan:
1. Lock acquisition: rst, then valid samples F,E,C,8 on consecutive cycles.
   -> locked = 0 through the 4th sample edge, locked = 1 on the following cycle.
   -> err_count = 0 and err_pulse never asserted.
2. Single corruption: locked after F,E,C,8, then feed 1,2,0,9,3 (0 replaces 4).
   -> exactly one err_pulse, one cycle after the 0 sample.
   -> err_count = 1, locked stays 1, zero_seen = 1.
   -> 9 and 3 match (flywheel).
3. Loss of lock: locked, then feed 4 consecutive wrong samples (e.g. 5,5,5,5 when 1,2,4,9 are expected).
   -> 4 err_pulses, err_count = 4, locked = 0 after the 4th.
   -> then A,5,B,7 relocks (locked = 1 after 7).
4. Valid gaps: sequence F,E,C,8,1 with in_valid low for 3 cycles between each sample.
   -> locks identically to scenario 1 (after 8), no err_pulse during gaps.
5. Saturation: ERR_CNT_W = 2, ERR_LIMIT = 15.
   -> after lock, 6 wrong samples give err_count = 3 (held, no wrap) and 6 err_pulses.
6. Reset mid-operation: locked with err_count = 2 and zero_seen = 1, assert rst for 1 cycle.
   -> next cycle: locked = 0, err_count = 0, zero_seen = 0, err_pulse = 0.
   -> F,E,C,8 relocks.
